// File: rtl/or1200_decryption_fsm.sv
// Multi-cycle load-path decryption engine.
//
// Inverts the store-path encryption one word at a time. A 32-bit ciphertext
// is accepted together with the 128-bit key and a per-access seed. One
// decryption round runs per clock, from round ROUNDS-1 down to round 0.
// busy is high while the rounds run. unstall pulses for one cycle when
// dataOut holds the new plaintext.
//
// Ports:
//   clk      - core clock, rising edge
//   rst      - asynchronous active-low reset
//   start    - request; samples dataIn, seed and key (accepted in IDLE/DONE)
//   abort    - cancel the operation in flight; has priority over start
//   dataIn   - ciphertext word
//   seedIn   - seed register field
//   seedAddr - seed address field
//   seedImm  - seed immediate field
//   enc_key  - cipher key
//   dataOut  - registered plaintext; changes only on completion or reset
//   busy     - high while rounds are running
//   unstall  - one-cycle pulse marking dataOut valid
module or1200_decryption_fsm #(
    parameter int unsigned ROUNDS = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    input  logic [31:0]  dataIn,
    input  logic [4:0]   seedIn,
    input  logic [4:0]   seedAddr,
    input  logic [10:0]  seedImm,
    input  logic [127:0] enc_key,
    output logic [31:0]  dataOut,
    output logic         busy,
    output logic         unstall
);

    localparam logic [3:0] CntInit = 4'(ROUNDS - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e         state_q, state_d;
    logic [31:0]    x_q, x_d;
    logic [31:0]    tweak_q, tweak_d;
    logic [127:0]   key_q, key_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [31:0]    data_out_q, data_out_d;

    logic           accept;
    logic [31:0]    key_word;
    logic [31:0]    round_key;
    logic [31:0]    x_sub;
    logic [31:0]    x_round;

    // Round datapath: x = rotr32(x - i, 3) ^ (K[i mod 4] ^ T), with i = cnt_q.
    always_comb begin
        key_word = key_q[127:96];
        unique case (cnt_q[1:0])
            2'd0:    key_word = key_q[127:96];
            2'd1:    key_word = key_q[95:64];
            2'd2:    key_word = key_q[63:32];
            default: key_word = key_q[31:0];
        endcase
        round_key = key_word ^ tweak_q;
        x_sub     = x_q - {28'd0, cnt_q};
        x_round   = {x_sub[2:0], x_sub[31:3]} ^ round_key;
    end

    // A new request is taken only when no round is running and no flush is pending.
    assign accept = start && !abort && (state_q == StIdle || state_q == StDone);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (abort) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (start) state_d = StRun;
                StRun:   if (cnt_q == 4'd0) state_d = StDone;
                StDone:  state_d = start ? StRun : StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs are decoded from the state alone.
    always_comb begin
        busy    = (state_q == StRun);
        unstall = (state_q == StDone);
    end

    // Datapath next-state.
    always_comb begin
        x_d        = x_q;
        tweak_d    = tweak_q;
        key_d      = key_q;
        cnt_d      = cnt_q;
        data_out_d = data_out_q;
        if (accept) begin
            x_d     = dataIn;
            tweak_d = {seedImm, seedAddr, seedIn, 11'd0};
            key_d   = enc_key;
            cnt_d   = CntInit;
        end else if (state_q == StRun && !abort) begin
            x_d = x_round;
            if (cnt_q == 4'd0) begin
                data_out_d = x_round;
            end else begin
                cnt_d = cnt_q - 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_q        <= '0;
            tweak_q    <= '0;
            key_q      <= '0;
            cnt_q      <= '0;
            data_out_q <= '0;
        end else begin
            x_q        <= x_d;
            tweak_q    <= tweak_d;
            key_q      <= key_d;
            cnt_q      <= cnt_d;
            data_out_q <= data_out_d;
        end
    end

    assign dataOut = data_out_q;

endmodule

// File: tb/tb_or1200_decryption_fsm.sv
// Self-checking bench for or1200_decryption_fsm.
// Three instances (ROUNDS = 1, 2, 4) share clock, reset and data inputs;
// each has its own start/abort. Expected words go into a per-instance
// queue when a request is issued; a monitor pops them on unstall.
module tb_or1200_decryption_fsm;

    typedef struct {
        logic [31:0] data;
        int          due;
    } sb_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [2:0]   start_v = '0;
    logic [2:0]   abort_v = '0;
    logic [31:0]  data_in = '0;
    logic [4:0]   seed_in = '0;
    logic [4:0]   seed_addr = '0;
    logic [10:0]  seed_imm = '0;
    logic [127:0] key = '0;
    logic [31:0]  dout [3];
    logic [2:0]   busy_v;
    logic [2:0]   unstall_v;

    int           rnds [3] = '{1, 2, 4};
    sb_t          q [3][$];
    logic [31:0]  last_out [3] = '{32'd0, 32'd0, 32'd0};
    int           cyc = 0;
    int           n_tests = 0;
    int           n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    or1200_decryption_fsm #(.ROUNDS(1)) u_r1 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .dataIn(data_in),
        .seedIn(seed_in), .seedAddr(seed_addr), .seedImm(seed_imm), .enc_key(key),
        .dataOut(dout[0]), .busy(busy_v[0]), .unstall(unstall_v[0])
    );
    or1200_decryption_fsm #(.ROUNDS(2)) u_r2 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .dataIn(data_in),
        .seedIn(seed_in), .seedAddr(seed_addr), .seedImm(seed_imm), .enc_key(key),
        .dataOut(dout[1]), .busy(busy_v[1]), .unstall(unstall_v[1])
    );
    or1200_decryption_fsm u_r4 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .dataIn(data_in),
        .seedIn(seed_in), .seedAddr(seed_addr), .seedImm(seed_imm), .enc_key(key),
        .dataOut(dout[2]), .busy(busy_v[2]), .unstall(unstall_v[2])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference cipher: forward encryption from the round rules.
    function automatic logic [31:0] encrypt(input logic [31:0] pt, input logic [127:0] k,
                                            input logic [31:0] t, input int r);
        logic [31:0] x, y, rk;
        x = pt;
        for (int i = 0; i < r; i++) begin
            rk = k[127 - 32 * (i % 4) -: 32] ^ t;
            y  = x ^ rk;
            x  = ((y << 3) | (y >> 29)) + 32'(i);
        end
        return x;
    endfunction

    function automatic logic [31:0] tweak_of(input logic [4:0] si, input logic [4:0] sa,
                                             input logic [10:0] sm);
        return (32'(sm) << 21) | (32'(sa) << 16) | (32'(si) << 11);
    endfunction

    // Monitor: compares output on unstall, otherwise checks dataOut is held.
    always @(negedge clk) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                if (unstall_v[i]) begin
                    if (q[i].size() == 0) begin
                        chk($sformatf("unexpected_unstall[%0d]", i), 32'd1, 32'd0);
                    end else begin
                        sb_t e;
                        e = q[i].pop_front();
                        chk($sformatf("data[%0d]", i), dout[i], e.data);
                        chk($sformatf("latency[%0d]", i), 32'(cyc), 32'(e.due));
                        last_out[i] = e.data;
                    end
                end else begin
                    chk($sformatf("hold[%0d]", i), dout[i], last_out[i]);
                end
            end
        end
    end

    // Call just after a negedge: drives the request, pushes the expectation.
    task automatic issue(input int i, input logic [31:0] ct, input logic [127:0] k,
                         input logic [4:0] si, input logic [4:0] sa, input logic [10:0] sm,
                         input logic [31:0] exp);
        sb_t e;
        data_in    = ct;
        key        = k;
        seed_in    = si;
        seed_addr  = sa;
        seed_imm   = sm;
        start_v[i] = 1'b1;
        e.data = exp;
        e.due  = cyc + 1 + rnds[i];
        q[i].push_back(e);
        @(negedge clk);
        start_v[i] = 1'b0;
    endtask

    task automatic wait_done(input int i);
        for (int k = 0; k < 64; k++) begin
            if (unstall_v[i]) return;
            @(negedge clk);
        end
        chk($sformatf("timeout[%0d]", i), 32'd1, 32'd0);
    endtask

    task automatic rand_req(output logic [31:0] pt, output logic [31:0] ct,
                            output logic [127:0] k, output logic [4:0] si,
                            output logic [4:0] sa, output logic [10:0] sm);
        pt = $urandom;
        k  = {$urandom, $urandom, $urandom, $urandom};
        si = 5'($urandom);
        sa = 5'($urandom);
        sm = 11'($urandom);
        ct = encrypt(pt, k, tweak_of(si, sa, sm), 4);
    endtask

    initial begin
        logic [31:0]  pt, ct;
        logic [127:0] k;
        logic [4:0]   si, sa;
        logic [10:0]  sm;

        // Reset held with start asserted and random inputs.
        start_v = 3'b111;
        for (int c = 0; c < 3; c++) begin
            data_in = $urandom;
            key     = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                chk($sformatf("rst_dout[%0d]", i), dout[i], 32'd0);
                chk($sformatf("rst_busy[%0d]", i), 32'(busy_v[i]), 32'd0);
                chk($sformatf("rst_unstall[%0d]", i), 32'(unstall_v[i]), 32'd0);
            end
        end
        start_v = '0;
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("idle_busy", 32'(busy_v), 32'd0);
        end

        // Directed vectors with zero key.
        issue(0, 32'h0000_0008, '0, 5'd0, 5'd0, 11'd0, 32'h0000_0001);
        wait_done(0);
        @(negedge clk);
        issue(0, 32'h0000_4000, '0, 5'd1, 5'd0, 11'd0, 32'h0000_0000);
        wait_done(0);
        @(negedge clk);
        issue(1, 32'h0000_0041, '0, 5'd0, 5'd0, 11'd0, 32'h0000_0001);
        chk("r2_busy_c1", 32'(busy_v[1]), 32'd1);
        @(negedge clk);
        chk("r2_busy_c2", 32'(busy_v[1]), 32'd1);
        wait_done(1);
        chk("r2_done_busy", 32'(busy_v[1]), 32'd0);
        @(negedge clk);

        // Random round trips; inputs disturbed and start pulsed during RUN.
        for (int t = 0; t < 12; t++) begin
            rand_req(pt, ct, k, si, sa, sm);
            issue(2, ct, k, si, sa, sm, pt);
            chk("r4_busy", 32'(busy_v[2]), 32'd1);
            for (int c = 0; c < 2; c++) begin
                data_in    = $urandom;
                key        = {$urandom, $urandom, $urandom, $urandom};
                seed_in    = 5'($urandom);
                seed_imm   = 11'($urandom);
                start_v[2] = 1'b1;
                @(negedge clk);
            end
            start_v[2] = 1'b0;
            wait_done(2);
            chk("r4_done_busy", 32'(busy_v[2]), 32'd0);
            // Odd iterations hand straight into a back-to-back request.
            if (t % 2 == 1) begin
                rand_req(pt, ct, k, si, sa, sm);
                issue(2, ct, k, si, sa, sm, pt);
                chk("b2b_busy", 32'(busy_v[2]), 32'd1);
                wait_done(2);
            end
            @(negedge clk);
        end

        // Abort mid-RUN: no output, previous word held, then normal operation.
        rand_req(pt, ct, k, si, sa, sm);
        issue(2, ct, k, si, sa, sm, pt);
        @(negedge clk);
        abort_v[2] = 1'b1;
        void'(q[2].pop_back());
        @(negedge clk);
        abort_v[2] = 1'b0;
        chk("abort_busy", 32'(busy_v[2]), 32'd0);
        repeat (6) @(negedge clk);
        rand_req(pt, ct, k, si, sa, sm);
        issue(2, ct, k, si, sa, sm, pt);
        wait_done(2);

        // Abort in DONE blocks a simultaneous start.
        start_v[2] = 1'b1;
        abort_v[2] = 1'b1;
        data_in    = $urandom;
        @(negedge clk);
        start_v[2] = 1'b0;
        abort_v[2] = 1'b0;
        chk("abort_done_busy", 32'(busy_v[2]), 32'd0);
        chk("abort_done_unstall", 32'(unstall_v[2]), 32'd0);
        @(negedge clk);
        chk("abort_done_idle", 32'(busy_v[2]), 32'd0);

        // Async reset mid-RUN clears outputs immediately.
        rand_req(pt, ct, k, si, sa, sm);
        issue(2, ct, k, si, sa, sm, pt);
        @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("rst_mid_dout", dout[2], 32'd0);
        chk("rst_mid_busy", 32'(busy_v[2]), 32'd0);
        chk("rst_mid_unstall", 32'(unstall_v[2]), 32'd0);
        for (int i = 0; i < 3; i++) begin
            q[i].delete();
            last_out[i] = 32'd0;
        end
        @(negedge clk);
        #2 rst = 1'b1;
        @(negedge clk);
        rand_req(pt, ct, k, si, sa, sm);
        issue(2, ct, k, si, sa, sm, pt);
        wait_done(2);
        repeat (3) @(negedge clk);

        for (int i = 0; i < 3; i++) begin
            chk($sformatf("sb_drain[%0d]", i), 32'(q[i].size()), 32'd0);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/or1200_decryption_fsm.md
Name: or1200_decryption_fsm

Overview:
Multi-cycle decryption engine for the load path. It inverts the store-path encryption FSM word-for-word: a 32-bit ciphertext read from cache memory is turned back into plaintext using the shared 128-bit key and the per-access seed (seedIn/seedAddr/seedImm). The block sits beside the load-side encryption wrapper. It stalls the pipeline while rounds run and raises unstall for one cycle when plaintext is ready.

Parameters:
ROUNDS, 4, number of cipher rounds; legal range 1..16; must equal the encryption engine's round count.

Ports:
clk  input  1  core clock, rising edge
rst  input  1  asynchronous, active-low reset (asserted when 0)
start  input  1  request: sample dataIn, seed and key this cycle
abort  input  1  cancel the operation in flight (pipeline flush)
dataIn  input  32  ciphertext word
seedIn  input  5  seed register field
seedAddr  input  5  seed address field
seedImm  input  11  seed immediate field
enc_key  input  128  cipher key
dataOut  output  32  plaintext, registered
busy  output  1  high while rounds are running
unstall  output  1  one-cycle pulse: dataOut valid

Behaviour:
- Reset: rst low asynchronously forces state=IDLE, dataOut=0, busy=0, unstall=0, round counter=0, all internal latches 0.
- Tweak: T = {seedImm, seedAddr, seedIn, 11'b0} (32 bits).
- Key words: K[j] = enc_key[127-32j -: 32] for j=0..3.
- Round key for round i: RK[i] = K[i mod 4] ^ T.
- Encryption round i (reference only, for i = 0..ROUNDS-1): x = rotl32(x ^ RK[i], 3) + i.
- Decryption round i (implemented, for i = ROUNDS-1 down to 0): x = rotr32(x - i, 3) ^ RK[i].
- All arithmetic is modulo 2^32.
- State machine:
  - IDLE: busy=0, unstall=0. If start=1: latch dataIn into working reg x, latch T and enc_key, set counter=ROUNDS-1, go to RUN.
  - RUN: busy=1. Each clock applies decryption round i=counter to x. If counter==0: write the result to dataOut and go to DONE. Otherwise decrement counter.
  - DONE: unstall=1 for exactly this cycle, busy=0. If start=1, accept a new request (same latching as IDLE) and go to RUN. Otherwise go to IDLE.
- Latency: start sampled at edge E0; unstall is high in the cycle following edge E_ROUNDS (ROUNDS cycles after acceptance).
- Throughput: back-to-back issue via start in DONE gives one word per ROUNDS+1 cycles.
- start in RUN is ignored; the requester must hold it or reissue.
- Key and seed are used only as latched at acceptance; input changes during RUN have no effect.
- dataOut holds its last value until the next completion; it never changes in IDLE or RUN.
- abort=1 in any state: next state IDLE, busy=0, no unstall, dataOut unchanged. abort has priority over start in the same cycle.
- abort in DONE suppresses nothing already output (unstall is combinational from state) but prevents a new start being accepted.
- Reset mid-operation: the operation is discarded and dataOut returns to 0.
- Counter width: 4 bits.

Test Plan:
- Reset: hold rst=0 with start=1 and random inputs -> dataOut=0, busy=0, unstall=0 throughout. Release rst -> stays IDLE until start.
- ROUNDS=1, key=0, seeds=0: start with dataIn=0x00000008 -> unstall one cycle after acceptance, dataOut=0x00000001.
- ROUNDS=2, key=0, seeds=0: dataIn=0x00000041 -> busy for 2 cycles, unstall on the 2nd cycle after acceptance, dataOut=0x00000001.
- ROUNDS=1, key=0, seedIn=1 (T=0x00000800): dataIn=0x00004000 -> dataOut=0x00000000.
- Default ROUNDS=4 with random key/seed/plaintext: encrypt via reference model, feed ciphertext, and also change seed/key and pulse start during RUN -> dataOut equals the original plaintext, extra starts ignored.
- Back-to-back and abort:
  - Start in DONE -> new run begins immediately, one unstall per word.
  - abort mid-RUN -> no unstall, dataOut keeps the previous word, next start works normally.
  - Async reset mid-RUN -> outputs clear immediately.
